// File: rtl/int_to_fp_pipe_if.sv
// Handshake bundle for the integer-to-FP converter: request side, result side and flush.
// The converter uses the slave view and its producer/consumer uses the master view.
interface int_to_fp_pipe_if #(
  parameter int TAG_W = 8
);
  logic             io_flush;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [63:0]      io_in_int;
  logic             io_in_sign;
  logic             io_in_long;
  logic             io_in_fmt;
  logic [2:0]       io_in_rm;
  logic [TAG_W-1:0] io_in_tag;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [63:0]      io_out_result;
  logic [4:0]       io_out_fflags;
  logic [TAG_W-1:0] io_out_tag;

  modport master (
    output io_flush, io_in_valid, io_in_int, io_in_sign, io_in_long, io_in_fmt,
           io_in_rm, io_in_tag, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_result, io_out_fflags, io_out_tag
  );

  modport slave (
    input  io_flush, io_in_valid, io_in_int, io_in_sign, io_in_long, io_in_fmt,
           io_in_rm, io_in_tag, io_out_ready,
    output io_in_ready, io_out_valid, io_out_result, io_out_fflags, io_out_tag
  );
endinterface

// File: rtl/int_to_fp_pipe.sv
// Pipelined int-to-FP converter (32/64-bit signed/unsigned source, FP32/FP64 result)
// with valid/ready backpressure, flush and a tag that travels with each op.
module int_to_fp_pipe #(
  parameter int XLEN        = 64,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 8
) (
  input logic             clock,
  input logic             reset,
  int_to_fp_pipe_if.slave io
);

  typedef struct packed {
    logic             sign;
    logic             is_zero;
    logic             fmt;
    logic [2:0]       rm;
    logic [5:0]       lz;
    logic [62:0]      frac;
    logic [TAG_W-1:0] tag;
  } pre_t;

  typedef struct packed {
    logic             sign;
    logic             is_zero;
    logic             fmt;
    logic             nx;
    logic [10:0]      expo;
    logic [51:0]      mant;
    logic [TAG_W-1:0] tag;
  } rnd_t;

  typedef struct packed {
    logic [63:0]      result;
    logic [4:0]       fflags;
    logic [TAG_W-1:0] tag;
  } out_t;

  function automatic pre_t prenorm(input logic [XLEN-1:0] opnd, input logic sgn,
                                   input logic lng, input logic fmt,
                                   input logic [2:0] rm, input logic [TAG_W-1:0] tag);
    pre_t            p;
    logic [XLEN-1:0] ext;
    logic [XLEN-1:0] mag;
    logic [XLEN-1:0] norm;
    logic [5:0]      lz;
    if (lng)
      ext = opnd;
    else if (sgn)
      ext = {{(XLEN-32){opnd[31]}}, opnd[31:0]};
    else
      ext = {{(XLEN-32){1'b0}}, opnd[31:0]};
    mag = (sgn && ext[XLEN-1]) ? -ext : ext;
    // Upward scan so the highest set bit wins.
    lz = '0;
    for (int i = 0; i < XLEN; i++)
      if (mag[i]) lz = 6'(XLEN - 1 - i);
    norm      = mag << lz;
    p.sign    = sgn && ext[XLEN-1];
    p.is_zero = (mag == '0);
    p.fmt     = fmt;
    p.rm      = rm;
    p.lz      = lz;
    p.frac    = norm[62:0];
    p.tag     = tag;
    return p;
  endfunction

  function automatic rnd_t round_op(input pre_t p);
    rnd_t        r;
    logic [52:0] m;
    logic [10:0] e;
    logic        g;
    logic        s;
    logic        up;
    if (p.fmt) begin
      m = {1'b0, p.frac[62:11]};
      g = p.frac[10];
      s = |p.frac[9:0];
      e = 11'd1086 - {5'd0, p.lz};
    end else begin
      m = {30'd0, p.frac[62:40]};
      g = p.frac[39];
      s = |p.frac[38:0];
      e = 11'd190 - {5'd0, p.lz};
    end
    case (p.rm)
      3'd1:    up = 1'b0;
      3'd2:    up = (g | s) & p.sign;
      3'd3:    up = (g | s) & ~p.sign;
      3'd4:    up = g;
      default: up = g & (s | m[0]);
    endcase
    m = m + 53'(up);
    // Mantissa overflowed into the hidden-bit position: bump exponent, fraction wraps to 0.
    if ((p.fmt && m[52]) || (!p.fmt && m[23])) begin
      e = e + 11'd1;
      m = '0;
    end
    r.sign    = p.sign;
    r.is_zero = p.is_zero;
    r.fmt     = p.fmt;
    r.nx      = g | s;
    r.expo    = e;
    r.mant    = m[51:0];
    r.tag     = p.tag;
    return r;
  endfunction

  function automatic out_t pack(input rnd_t r);
    out_t o;
    if (r.is_zero)
      o.result = r.fmt ? 64'd0 : {32'hFFFF_FFFF, 32'd0};
    else if (r.fmt)
      o.result = {r.sign, r.expo, r.mant};
    else
      o.result = {32'hFFFF_FFFF, r.sign, r.expo[7:0], r.mant[22:0]};
    o.fflags = {4'b0000, r.nx};
    o.tag    = r.tag;
    return o;
  endfunction

  logic [PIPE_STAGES-1:0] valid_q, valid_d;
  logic [PIPE_STAGES-1:0] adv;
  logic [PIPE_STAGES-1:0] load;
  logic                   chain_free;
  logic                   in_ready;
  pre_t                   pre_c;
  out_t                   out_c;
  out_t                   out_q, out_d;

  // Walk from the output backwards: a stage advances when everything below it can take data.
  always_comb begin
    chain_free = io.io_out_ready;
    adv        = '0;
    load       = '0;
    valid_d    = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      adv[k]     = valid_q[k] && chain_free;
      chain_free = !valid_q[k] || adv[k];
    end
    in_ready = chain_free && !io.io_flush;
    load[0]  = io.io_in_valid && in_ready;
    for (int k = 1; k < PIPE_STAGES; k++)
      load[k] = adv[k-1];
    for (int k = 0; k < PIPE_STAGES; k++)
      valid_d[k] = io.io_flush ? 1'b0 : (load[k] || (valid_q[k] && !adv[k]));
  end

  always_comb begin
    pre_c = prenorm(io.io_in_int, io.io_in_sign, io.io_in_long, io.io_in_fmt,
                    io.io_in_rm, io.io_in_tag);
  end

  if (PIPE_STAGES == 1) begin : g_s1
    always_comb out_c = pack(round_op(pre_c));
  end else if (PIPE_STAGES == 2) begin : g_s2
    pre_t pre_q, pre_d;
    always_comb pre_d = load[0] ? pre_c : pre_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) pre_q <= '0;
      else        pre_q <= pre_d;
    end
    always_comb out_c = pack(round_op(pre_q));
  end else begin : g_s3
    pre_t pre_q, pre_d;
    rnd_t rnd_q, rnd_d;
    always_comb pre_d = load[0] ? pre_c : pre_q;
    always_comb rnd_d = load[1] ? round_op(pre_q) : rnd_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        pre_q <= '0;
        rnd_q <= '0;
      end else begin
        pre_q <= pre_d;
        rnd_q <= rnd_d;
      end
    end
    always_comb out_c = pack(rnd_q);
  end

  // Output register only loads on a real transfer so it stays frozen under backpressure.
  always_comb out_d = load[PIPE_STAGES-1] ? out_c : out_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign io.io_in_ready   = in_ready;
  assign io.io_out_valid  = valid_q[PIPE_STAGES-1];
  assign io.io_out_result = out_q.result;
  assign io.io_out_fflags = out_q.fflags;
  assign io.io_out_tag    = out_q.tag;

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Scoreboard bench for int_to_fp_pipe: directed conversions, backpressure, flush,
// mid-flight reset and a randomised run checked against an independent reference model.
module tb_int_to_fp_pipe;
  localparam int PIPE_STAGES = 2;
  localparam int TAG_W       = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int_to_fp_pipe_if #(.TAG_W(TAG_W)) bus ();

  int_to_fp_pipe #(.XLEN(64), .PIPE_STAGES(PIPE_STAGES), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0]      result;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
    bit               lat_check;
    int               acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   cyc       = 0;
  bit   rand_bp   = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Reference: locate MSB, shift down to the target precision, round on the remainder.
  function automatic void fpModel(input logic [63:0] v, input logic sgn, input logic lng,
                                  input logic fmt, input logic [2:0] rm,
                                  output logic [63:0] res, output logic [4:0] fl);
    logic [63:0] ext, mag, q, rem, half;
    logic        neg, inexact, up;
    int          p, prec, sh;
    ext  = lng ? v : (sgn ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]});
    neg  = sgn && ext[63];
    mag  = neg ? (~ext + 64'd1) : ext;
    res  = fmt ? 64'd0 : {32'hFFFF_FFFF, 32'd0};
    fl   = 5'd0;
    if (mag == 64'd0) return;
    p = 63;
    while (p > 0 && !mag[p]) p--;
    prec    = fmt ? 53 : 24;
    inexact = 1'b0;
    rem     = 64'd0;
    half    = 64'd0;
    if (p < prec) begin
      q = mag << (prec - 1 - p);
    end else begin
      sh      = p - (prec - 1);
      q       = mag >> sh;
      rem     = mag & ((64'd1 << sh) - 64'd1);
      half    = 64'd1 << (sh - 1);
      inexact = (rem != 64'd0);
    end
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = inexact && neg;
      3'd3:    up = inexact && !neg;
      3'd4:    up = inexact && (rem >= half);
      default: up = inexact && ((rem > half) || (rem == half && q[0]));
    endcase
    if (up) q = q + 64'd1;
    if (q == (64'd1 << prec)) begin
      q = q >> 1;
      p++;
    end
    if (fmt) res = {neg, 11'(p + 1023), q[51:0]};
    else     res = {32'hFFFF_FFFF, neg, 8'(p + 127), q[22:0]};
    fl = {4'd0, inexact};
  endfunction

  // Output side: every transfer pops the oldest expectation.
  always @(negedge clock) begin
    if (bus.io_out_valid && bus.io_out_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("spurious_out", 64'(bus.io_out_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("result", bus.io_out_result, e.result);
        checkOutput("fflags", 64'(bus.io_out_fflags), 64'(e.flags));
        checkOutput("tag", 64'(bus.io_out_tag), 64'(e.tag));
        if (e.lat_check) checkOutput("latency", 64'(cyc - e.acc_cyc), 64'(PIPE_STAGES));
      end
    end
  end

  // Presents one op for up to max_cycles; entered and left just after a rising edge.
  task automatic applyStimulus(input logic [63:0] v, input logic sgn, input logic lng,
                               input logic fmt, input logic [2:0] rm,
                               input logic [TAG_W-1:0] tag, input logic [63:0] want_res,
                               input logic [4:0] want_fl, input bit lat, input int max_cycles,
                               input bit must, output bit accepted);
    exp_t e;
    bus.io_in_valid = 1'b1;
    bus.io_in_int   = v;
    bus.io_in_sign  = sgn;
    bus.io_in_long  = lng;
    bus.io_in_fmt   = fmt;
    bus.io_in_rm    = rm;
    bus.io_in_tag   = tag;
    accepted        = 1'b0;
    for (int c = 0; c < max_cycles && !accepted; c++) begin
      if (rand_bp) bus.io_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (bus.io_in_ready) begin
        accepted    = 1'b1;
        e.result    = want_res;
        e.flags     = want_fl;
        e.tag       = tag;
        e.lat_check = lat;
        e.acc_cyc   = cyc;
        sb_q.push_back(e);
      end
      @(posedge clock);
      #1;
    end
    bus.io_in_valid = 1'b0;
    if (must) checkOutput("accept", 64'(accepted), 64'd1);
  endtask

  task automatic modelOp(input logic [63:0] v, input logic sgn, input logic lng,
                         input logic fmt, input logic [2:0] rm, input logic [TAG_W-1:0] tag,
                         input bit lat, input int max_cycles, input bit must,
                         output bit accepted);
    logic [63:0] r;
    logic [4:0]  f;
    fpModel(v, sgn, lng, fmt, rm, r, f);
    applyStimulus(v, sgn, lng, fmt, rm, tag, r, f, lat, max_cycles, must, accepted);
  endtask

  task automatic waitDrain();
    bus.io_out_ready = 1'b1;
    for (int c = 0; c < 200 && sb_q.size() != 0; c++) @(posedge clock);
    @(negedge clock);
    checkOutput("drain", 64'(sb_q.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic directedOp(input logic [63:0] v, input logic sgn, input logic lng,
                            input logic fmt, input logic [2:0] rm, input logic [TAG_W-1:0] tag,
                            input logic [63:0] res, input logic [4:0] fl);
    bit acc;
    applyStimulus(v, sgn, lng, fmt, rm, tag, res, fl, 1'b1, 20, 1'b1, acc);
    waitDrain();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  logic [63:0]      bp_v [6];
  logic [TAG_W-1:0] bp_t [6];
  int               n_acc;
  bit               acc;

  initial begin
    bus.io_flush     = 1'b0;
    bus.io_in_valid  = 1'b0;
    bus.io_in_int    = '0;
    bus.io_in_sign   = 1'b0;
    bus.io_in_long   = 1'b0;
    bus.io_in_fmt    = 1'b0;
    bus.io_in_rm     = '0;
    bus.io_in_tag    = '0;
    bus.io_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkOutput("rst_out_valid", 64'(bus.io_out_valid), 64'd0);
    checkOutput("rst_result", bus.io_out_result, 64'd0);
    checkOutput("rst_fflags", 64'(bus.io_out_fflags), 64'd0);
    checkOutput("rst_tag", 64'(bus.io_out_tag), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.io_in_ready), 64'd1);
    @(posedge clock);
    #1;

    $display("[TB] directed conversions");
    directedOp(64'd1, 1, 1, 1, 3'd0, 8'h11, 64'h3FF0000000000000, 5'h00);
    directedOp(64'hFFFFFFFFFFFFFFFF, 1, 1, 0, 3'd0, 8'h12, 64'hFFFFFFFFBF800000, 5'h00);
    directedOp(64'hFFFFFFFFFFFFFFFF, 0, 1, 1, 3'd0, 8'h13, 64'h43F0000000000000, 5'h01);
    directedOp(64'hFFFFFFFFFFFFFFFF, 0, 1, 1, 3'd1, 8'h14, 64'h43EFFFFFFFFFFFFF, 5'h01);
    directedOp(64'h0000000080000000, 1, 0, 1, 3'd0, 8'h15, 64'hC1E0000000000000, 5'h00);
    directedOp(64'hFFFFFFFF80000000, 0, 0, 1, 3'd0, 8'h16, 64'h41E0000000000000, 5'h00);
    directedOp(64'd16777217, 0, 1, 0, 3'd0, 8'h17, 64'hFFFFFFFF4B800000, 5'h01);
    directedOp(64'd16777217, 0, 1, 0, 3'd3, 8'h18, 64'hFFFFFFFF4B800001, 5'h01);
    directedOp(64'd16777217, 0, 1, 0, 3'd4, 8'h19, 64'hFFFFFFFF4B800001, 5'h01);
    directedOp(64'hFFFFFFFFFEFFFFFF, 1, 1, 0, 3'd2, 8'h1A, 64'hFFFFFFFFCB800001, 5'h01);
    directedOp(64'd16777219, 0, 1, 0, 3'd7, 8'h1B, 64'hFFFFFFFF4B800002, 5'h01);
    directedOp(64'd0, 1, 1, 1, 3'd2, 8'h1C, 64'h0000000000000000, 5'h00);
    directedOp(64'd0, 0, 0, 0, 3'd0, 8'h1D, 64'hFFFFFFFF00000000, 5'h00);
    directedOp(64'h8000000000000000, 1, 1, 1, 3'd0, 8'h1E, 64'hC3E0000000000000, 5'h00);

    $display("[TB] backpressure");
    for (int i = 0; i < 6; i++) begin
      bp_v[i] = {$urandom, $urandom} >> $urandom_range(0, 40);
      bp_t[i] = 8'(8'hA0 + i);
    end
    bus.io_out_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      if (n_acc < 6) begin
        modelOp(bp_v[n_acc], 1'b1, 1'b1, 1'b1, 3'd0, bp_t[n_acc], 1'b0, 1, 1'b0, acc);
        if (acc) n_acc++;
      end
    end
    checkOutput("bp_accepted", 64'(n_acc), 64'(PIPE_STAGES));
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      checkOutput("bp_in_ready", 64'(bus.io_in_ready), 64'd0);
      checkOutput("bp_hold_valid", 64'(bus.io_out_valid), 64'd1);
      if (sb_q.size() != 0) begin
        checkOutput("bp_hold_result", bus.io_out_result, sb_q[0].result);
        checkOutput("bp_hold_tag", 64'(bus.io_out_tag), 64'(sb_q[0].tag));
      end
      @(posedge clock);
      #1;
    end
    bus.io_out_ready = 1'b1;
    while (n_acc < 6) begin
      modelOp(bp_v[n_acc], 1'b1, 1'b1, 1'b1, 3'd0, bp_t[n_acc], 1'b0, 20, 1'b1, acc);
      n_acc++;
    end
    waitDrain();

    $display("[TB] flush");
    bus.io_out_ready = 1'b0;
    modelOp(64'd12345, 0, 1, 1, 3'd0, 8'hB1, 1'b0, 10, 1'b1, acc);
    modelOp(64'd54321, 0, 1, 1, 3'd0, 8'hB2, 1'b0, 1, 1'b0, acc);
    bus.io_in_valid = 1'b1;
    bus.io_in_int   = 64'd777;
    bus.io_in_tag   = 8'hB3;
    bus.io_flush    = 1'b1;
    @(negedge clock);
    checkOutput("flush_in_ready", 64'(bus.io_in_ready), 64'd0);
    @(posedge clock);
    #1;
    bus.io_flush    = 1'b0;
    bus.io_in_valid = 1'b0;
    sb_q.delete();
    @(negedge clock);
    checkOutput("flush_out_valid", 64'(bus.io_out_valid), 64'd0);
    @(posedge clock);
    #1;
    bus.io_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("flush_quiet", 64'(bus.io_out_valid), 64'd0);
    end
    @(posedge clock);
    #1;
    directedOp(64'd3, 1, 0, 1, 3'd0, 8'hB4, 64'h4008000000000000, 5'h00);

    $display("[TB] reset mid-flight");
    bus.io_out_ready = 1'b0;
    modelOp(64'd99, 0, 1, 0, 3'd0, 8'hC1, 1'b0, 10, 1'b1, acc);
    repeat (PIPE_STAGES - 1) @(posedge clock);
    #1;
    checkOutput("pre_rst_valid", 64'(bus.io_out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(bus.io_out_valid), 64'd0);
    checkOutput("midrst_result", bus.io_out_result, 64'd0);
    checkOutput("midrst_tag", 64'(bus.io_out_tag), 64'd0);
    sb_q.delete();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    bus.io_out_ready = 1'b1;
    directedOp(64'd2, 0, 1, 0, 3'd0, 8'hC2, 64'hFFFFFFFF40000000, 5'h00);

    $display("[TB] random run");
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      modelOp({$urandom, $urandom} >> $urandom_range(0, 63), 1'($urandom), 1'($urandom),
              1'($urandom), 3'($urandom_range(0, 7)), 8'(i), 1'b0, 50, 1'b1, acc);
    end
    rand_bp = 1'b0;
    waitDrain();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
